// File: rtl/reg_bus_sequencer.sv
// reg_bus_sequencer: writer-side controller for the register-bank bus.
// Accepts one transfer request, enables two source registers onto the A/B
// buses, captures the operands for the ALU, waits (bounded) for the result
// and writes it back over the C bus with a one-hot load strobe.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready request handshake; ready only in IDLE
//   req_src_a/_b/_dst   register indices, latched at acceptance
//   req_wb              1 = write result back, 0 = discard
//   rd_en_a/rd_en_b     one-hot bank read enables (READ and CAPTURE only)
//   bus_a_in/bus_b_in   bank output data
//   alu_a/alu_b         captured operands, held until the next capture
//   alu_start           one-cycle start pulse (first EXEC cycle)
//   alu_done/alu_result ALU completion and data
//   write_c/bus_c       one-hot load strobe (WRITE only) and C bus data
//   done/err            one-cycle completion pulse, error in the same cycle
//   busy                high in every state except IDLE
module reg_bus_sequencer #(
  parameter int unsigned NREG    = 8,
  parameter int unsigned W       = 16,
  parameter int unsigned IDW     = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [IDW-1:0]  req_src_a,
  input  logic [IDW-1:0]  req_src_b,
  input  logic [IDW-1:0]  req_dst,
  input  logic            req_wb,
  output logic [NREG-1:0] rd_en_a,
  output logic [NREG-1:0] rd_en_b,
  input  logic [W-1:0]    bus_a_in,
  input  logic [W-1:0]    bus_b_in,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  output logic            alu_start,
  input  logic            alu_done,
  input  logic [W-1:0]    alu_result,
  output logic [NREG-1:0] write_c,
  output logic [W-1:0]    bus_c,
  output logic            done,
  output logic            err,
  output logic            busy
);

  typedef enum logic [2:0] {StIdle, StRead, StCapture, StExec, StWrite, StDone} state_e;

  state_e         state_q;
  logic [IDW-1:0] src_a_q, src_b_q, dst_q;
  logic           wb_q;
  logic           bad_idx_q;
  logic [7:0]     cnt_q;

  function automatic logic in_range(input logic [IDW-1:0] idx);
    return int'(idx) < int'(NREG);
  endfunction

  // Out-of-range indices decode to an all-zero vector.
  function automatic logic [NREG-1:0] one_hot(input logic [IDW-1:0] idx);
    logic [NREG-1:0] oh;
    oh = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (int'(idx) == i) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      src_a_q   <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      wb_q      <= 1'b0;
      bad_idx_q <= 1'b0;
      cnt_q     <= '0;
      req_ready <= 1'b1;
      rd_en_a   <= '0;
      rd_en_b   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_start <= 1'b0;
      write_c   <= '0;
      bus_c     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            src_a_q   <= req_src_a;
            src_b_q   <= req_src_b;
            dst_q     <= req_dst;
            wb_q      <= req_wb;
            bad_idx_q <= !(in_range(req_src_a) && in_range(req_src_b) && in_range(req_dst));
            // Enables are registered here so they are live for the whole READ cycle.
            rd_en_a   <= one_hot(req_src_a);
            rd_en_b   <= one_hot(req_src_b);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state_q   <= StRead;
          end
        end
        StRead: state_q <= StCapture;
        StCapture: begin
          alu_a     <= in_range(src_a_q) ? bus_a_in : '0;
          alu_b     <= in_range(src_b_q) ? bus_b_in : '0;
          rd_en_a   <= '0;
          rd_en_b   <= '0;
          alu_start <= 1'b1;
          cnt_q     <= '0;
          state_q   <= StExec;
        end
        StExec: begin
          if (alu_start) begin
            // alu_done during the start cycle is deliberately ignored.
            alu_start <= 1'b0;
            cnt_q     <= 8'd1;
          end else if (alu_done) begin
            bus_c <= alu_result;
            if (wb_q) begin
              write_c <= one_hot(dst_q);
              state_q <= StWrite;
            end else begin
              done    <= 1'b1;
              err     <= bad_idx_q;
              state_q <= StDone;
            end
          end else if (cnt_q == 8'(TIMEOUT)) begin
            done    <= 1'b1;
            err     <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StWrite: begin
          write_c <= '0;
          done    <= 1'b1;
          err     <= bad_idx_q;
          state_q <= StDone;
        end
        StDone: begin
          done      <= 1'b0;
          err       <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Directed bench for reg_bus_sequencer with a small register-bank and ALU
// driven around it. Cycle k of a transfer is sampled 1 time unit after
// edge k-1, where edge 0 is the acceptance edge.
module tb_reg_bus_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_src_a, req_src_b, req_dst;
  logic        req_wb;
  logic [7:0]  rd_en_a, rd_en_b;
  logic [15:0] bus_a_in, bus_b_in;
  logic [15:0] alu_a, alu_b;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic [7:0]  write_c;
  logic [15:0] bus_c;
  logic        done, err, busy;

  reg_bus_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src_a  (req_src_a),
    .req_src_b  (req_src_b),
    .req_dst    (req_dst),
    .req_wb     (req_wb),
    .rd_en_a    (rd_en_a),
    .rd_en_b    (rd_en_b),
    .bus_a_in   (bus_a_in),
    .bus_b_in   (bus_b_in),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .write_c    (write_c),
    .bus_c      (bus_c),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Register bank: registered read mux, write on write_c.
  logic [15:0] regs [0:7];

  function automatic logic [15:0] bank_mux(input logic [7:0] en);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) if (en[i]) v = regs[i];
    return v;
  endfunction

  always @(posedge clk) begin
    bus_a_in <= bank_mux(rd_en_a);
    bus_b_in <= bank_mux(rd_en_b);
    for (int i = 0; i < 8; i++) if (write_c[i]) regs[i] <= bus_c;
  end

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-cycle trace of one transfer.
  logic [7:0]  tr_rda [0:31];
  logic [7:0]  tr_rdb [0:31];
  logic [7:0]  tr_wc  [0:31];
  logic [15:0] tr_aa  [0:31];
  logic [15:0] tr_ab  [0:31];
  logic [15:0] tr_bc  [0:31];
  logic        tr_st  [0:31];
  logic        tr_dn  [0:31];
  logic        tr_er  [0:31];
  logic        tr_rdy [0:31];
  logic        tr_bsy [0:31];

  // mode 1: alu_done in cycle 4 (second EXEC cycle); 2: only in cycle 3 (start cycle);
  // 0: never. poke: pulse req_valid (dst=7) while busy.
  task automatic run(input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] dst,
                     input logic wb, input int mode, input logic [15:0] res, input int ncyc,
                     input logic poke);
    req_src_a = sa;
    req_src_b = sb;
    req_dst   = dst;
    req_wb    = wb;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      tr_rda[k] = rd_en_a;   tr_rdb[k] = rd_en_b; tr_wc[k] = write_c;
      tr_aa[k]  = alu_a;     tr_ab[k]  = alu_b;   tr_bc[k] = bus_c;
      tr_st[k]  = alu_start; tr_dn[k]  = done;    tr_er[k] = err;
      tr_rdy[k] = req_ready; tr_bsy[k] = busy;
      alu_done   = (mode == 1 && k == 4) || (mode == 2 && k == 3);
      alu_result = alu_done ? res : 16'hdead;
      if (poke) begin
        req_valid = (k >= 2 && k <= 5);
        req_dst   = 3'd7;
      end
      @(posedge clk); #1;
    end
    alu_done  = 1'b0;
    req_valid = 1'b0;
  endtask

  function automatic int count_wc(input int n);
    int c;
    c = 0;
    for (int k = 1; k <= n; k++) if (tr_wc[k] != 8'h00) c++;
    return c;
  endfunction

  initial begin
    int ov;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    regs[1] = 16'h0005;
    regs[2] = 16'h0007;
    regs[4] = 16'h1234;
    regs[5] = 16'h5555;
    req_valid = 0; req_src_a = 0; req_src_b = 0; req_dst = 0; req_wb = 0;
    alu_done = 0; alu_result = 0;
    reset = 1'b1;
    #1;
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_outs", {rd_en_a, rd_en_b, write_c, done, err, alu_start}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic transfer R1+R2 -> R3 with write-back.
    run(3'd1, 3'd2, 3'd3, 1'b1, 1, 16'h000c, 7, 1'b0);
    check_eq("t1_rda_c1", tr_rda[1], 8'h02);
    check_eq("t1_rdb_c1", tr_rdb[1], 8'h04);
    check_eq("t1_rd_c2", {tr_rda[2], tr_rdb[2]}, 16'h0204);
    check_eq("t1_rd_c3", {tr_rda[3], tr_rdb[3]}, 16'h0000);
    check_eq("t1_start_c3", tr_st[3], 1);
    check_eq("t1_start_c4", tr_st[4], 0);
    check_eq("t1_ops_c3", {tr_aa[3], tr_ab[3]}, 32'h0005_0007);
    check_eq("t1_wc_c5", tr_wc[5], 8'h08);
    check_eq("t1_busc_c5", tr_bc[5], 16'h000c);
    check_eq("t1_wc_count", count_wc(7), 1);
    check_eq("t1_done_c5", tr_dn[5], 0);
    check_eq("t1_done_c6", {tr_dn[6], tr_er[6]}, 2'b10);
    check_eq("t1_ready_c7", {tr_rdy[6], tr_rdy[7], tr_bsy[7]}, 3'b010);
    check_eq("t1_r3", regs[3], 16'h000c);

    // Same request, result discarded.
    run(3'd1, 3'd2, 3'd3, 1'b0, 1, 16'h0011, 7, 1'b0);
    check_eq("t2_wc_count", count_wc(7), 0);
    check_eq("t2_done_c4", tr_dn[4], 0);
    check_eq("t2_done_c5", {tr_dn[5], tr_er[5]}, 2'b10);
    check_eq("t2_ready_c6", tr_rdy[6], 1);
    check_eq("t2_busc", tr_bc[5], 16'h0011);
    check_eq("t2_r3", regs[3], 16'h000c);

    // Same register as both sources and destination.
    run(3'd4, 3'd4, 3'd4, 1'b1, 1, 16'h2468, 7, 1'b0);
    check_eq("t3_rd_c1", {tr_rda[1], tr_rdb[1]}, 16'h1010);
    check_eq("t3_ops_c3", {tr_aa[3], tr_ab[3]}, 32'h1234_1234);
    check_eq("t3_wc_c5", tr_wc[5], 8'h10);
    check_eq("t3_busc_c5", tr_bc[5], 16'h2468);
    ov = 0;
    for (int k = 1; k <= 7; k++) if (((tr_rda[k] | tr_rdb[k]) & tr_wc[k]) != 0) ov++;
    check_eq("t3_overlap", ov, 0);
    check_eq("t3_r4", regs[4], 16'h2468);

    // ALU never answers: timeout after 15 post-start cycles.
    run(3'd1, 3'd2, 3'd6, 1'b1, 0, 16'h0000, 20, 1'b0);
    check_eq("t4_done_c18", tr_dn[18], 0);
    check_eq("t4_done_c19", {tr_dn[19], tr_er[19]}, 2'b11);
    check_eq("t4_wc_count", count_wc(20), 0);
    check_eq("t4_ready_c20", {tr_rdy[19], tr_rdy[20]}, 2'b01);

    // alu_done only in the start cycle is ignored.
    run(3'd1, 3'd2, 3'd6, 1'b1, 2, 16'h00ff, 20, 1'b0);
    check_eq("t5_done_c5", tr_dn[5], 0);
    check_eq("t5_done_c19", {tr_dn[19], tr_er[19]}, 2'b11);
    check_eq("t5_wc_count", count_wc(20), 0);
    check_eq("t5_r6", regs[6], 16'h0000);

    // Reset asserted while WRITE is driving write_c.
    run(3'd1, 3'd2, 3'd5, 1'b1, 1, 16'h000c, 4, 1'b0);
    check_eq("t6_wc_pre", write_c, 8'h20);
    #2 reset = 1'b1;
    #1;
    check_eq("t6_wc_rst", write_c, 8'h00);
    check_eq("t6_busy_rst", busy, 0);
    check_eq("t6_ready_rst", req_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("t6_r5_kept", regs[5], 16'h5555);

    // Normal transfer after reset, with req_valid pulsed while busy.
    run(3'd1, 3'd2, 3'd6, 1'b1, 1, 16'h000c, 7, 1'b1);
    check_eq("t7_wc_c5", tr_wc[5], 8'h40);
    check_eq("t7_done_c6", tr_dn[6], 1);
    check_eq("t7_r6", regs[6], 16'h000c);
    repeat (4) @(posedge clk);
    #1;
    check_eq("t7_idle", {busy, req_ready}, 2'b01);
    check_eq("t7_r7", regs[7], 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
